// File: rtl/panda_data_mem_responder.sv
// Single-port data memory slave with fixed wait states and a one-cycle response strobe.
// Optional macro PANDA_DMEM_BOUNDS_CHECK_EN: out-of-range words raise data_err_o instead of aliasing.
module panda_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [29:0] word_reg;
  logic [3:0]  we_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [29:0]   acc_word;
  logic [3:0]    acc_we;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_ok;
  logic          unused_addr;

  assign data_gnt_o    = (state_reg != WAIT);
  assign accept        = data_req_i & data_gnt_o;
  assign data_rvalid_o = (state_reg == RESP);
  assign data_rdata_o  = rdata_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_next   = WAIT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP);

  // With no wait states the access happens on the accept edge itself, so the
  // operands come straight from the ports; otherwise from the captured copy.
  assign acc_word  = (state_reg == WAIT) ? word_reg  : data_addr_i[31:2];
  assign acc_we    = (state_reg == WAIT) ? we_reg    : data_we_i;
  assign acc_wdata = (state_reg == WAIT) ? wdata_reg : data_wdata_i;
  assign acc_idx   = acc_word[AW-1:0];

`ifdef PANDA_DMEM_BOUNDS_CHECK_EN
  logic err_reg;
  assign acc_ok      = ({2'b00, acc_word} < 32'(DEPTH_WORDS));
  assign data_err_o  = err_reg;
  assign unused_addr = ^data_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i)           err_reg <= 1'b0;
    else if (enter_resp) err_reg <= ~acc_ok;
    else                 err_reg <= 1'b0;
  end
`else
  assign acc_ok      = 1'b1;
  assign data_err_o  = 1'b0;
  assign unused_addr = ^{data_addr_i[1:0], acc_word[29:AW]};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (enter_resp && acc_we == 4'b0000 && acc_ok) rdata_reg <= mem[acc_idx];
      else                                           rdata_reg <= 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      word_reg  <= data_addr_i[31:2];
      we_reg    <= data_we_i;
      wdata_reg <= data_wdata_i;
    end
  end

  // Contents survive reset; a reset edge cancels any access that would land on it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_we[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_panda_data_mem_responder.sv
// Four responders with WAIT_CYCLES 0..3 on one clock; scoreboard checks data, error and response cycle.
module tb_panda_data_mem_responder;

  logic        clk;
  logic        rst    [4];
  logic        req    [4];
  logic        gnt    [4];
  logic [31:0] addr   [4];
  logic [3:0]  we     [4];
  logic [31:0] wdata  [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    panda_data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(gi)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst[gi]),
      .data_req_i   (req[gi]),
      .data_gnt_o   (gnt[gi]),
      .data_addr_i  (addr[gi]),
      .data_we_i    (we[gi]),
      .data_wdata_i (wdata[gi]),
      .data_rvalid_o(rvalid[gi]),
      .data_rdata_o (rdata[gi]),
      .data_err_o   (err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop the oldest expectation of an instance whenever it strobes rvalid.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        if (rvalid[k] === 1'b1) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].inst == k) idx = i;
          end
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_rvalid inst=%0d cyc=%0d got rdata=%h err=%b required no response",
                     k, cyc, rdata[k], err[k]);
          end else begin
            if (rdata[k] !== sb[idx].rdata || err[k] !== sb[idx].err || cyc != sb[idx].cyc) begin
              bad++;
              $display("FAIL response inst=%0d got rdata=%h err=%b cyc=%0d required rdata=%h err=%b cyc=%0d",
                       k, rdata[k], err[k], cyc, sb[idx].rdata, sb[idx].err, sb[idx].cyc);
            end else begin
              $display("resp inst=%0d cyc=%0d rdata=%h err=%b ok", k, cyc, rdata[k], err[k]);
            end
            sb.delete(idx);
          end
        end else begin
          total++;
          if (rvalid[k] !== 1'b0 || rdata[k] !== 32'd0 || err[k] !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs inst=%0d cyc=%0d got rvalid=%b rdata=%h err=%b required 0/0/0",
                     k, cyc, rvalid[k], rdata[k], err[k]);
          end
        end
      end
    end
  end

  function automatic bit pending(input int k);
    foreach (sb[i]) if (sb[i].inst == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue(input int k, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit expect_resp, output int waited);
    exp_t e;
    req[k] = 1'b1; addr[k] = a; we[k] = w; wdata[k] = d;
    waited = 0;
    #1;
    while (gnt[k] !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (gnt[k] !== 1'b1) begin
      total++; bad++;
      $display("FAIL grant_timeout inst=%0d got gnt=%b required 1 within 50 cycles", k, gnt[k]);
    end else begin
      $display("req  inst=%0d cyc=%0d addr=%h we=%b wdata=%h waited=%0d", k, cyc + 1, a, w, d, waited);
      if (expect_resp) begin
        e.inst = k; e.rdata = er; e.err = ee; e.cyc = cyc + 1 + k;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0; we[k] = 4'b0000;
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (pending(k) && n < 30) begin
      @(negedge clk); #2;
      n++;
    end
    total++;
    if (pending(k)) begin
      bad++;
      $display("FAIL response_timeout inst=%0d got no rvalid required one within 30 cycles", k);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; we[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (gnt[k] !== 1'b1 || rvalid[k] !== 1'b0 || rdata[k] !== 32'd0 || err[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got gnt=%b rvalid=%b rdata=%h err=%b required 1/0/0/0",
                 k, gnt[k], rvalid[k], rdata[k], err[k]);
      end else begin
        $display("reset inst=%0d ok", k);
      end
      rst[k] = 1'b0;
    end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    int w;
    issue(1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, w);
    issue(1, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, w);
    idle(1);
    wait_done(1);
  endtask

  task automatic test_byte_lanes();
    int w;
    issue(1, 32'h20, 4'b1111, 32'h11223344, 32'h0, 1'b0, 1'b1, w);
    issue(1, 32'h20, 4'b0010, 32'h0000AA00, 32'h0, 1'b0, 1'b1, w);
    issue(1, 32'h20, 4'b0000, 32'h0, 32'h1122AA44, 1'b0, 1'b1, w);
    idle(1);
    wait_done(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [4] = '{32'h100, 32'h100, 32'h104, 32'h104};
    logic [3:0]  w_tab [4] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    logic [31:0] d_tab [4] = '{32'hAABBCCDD, 32'h0, 32'h01020304, 32'h0};
    logic [31:0] r_tab [4] = '{32'h0, 32'hAABBCCDD, 32'h0, 32'h01020304};
    int w;
    for (int i = 0; i < 4; i++) begin
      issue(0, a_tab[i], w_tab[i], d_tab[i], r_tab[i], 1'b0, 1'b1, w);
      total++;
      if (w != 0) begin
        bad++;
        $display("FAIL b2b_grant step=%0d got waited=%0d required 0", i, w);
      end
    end
    idle(0);
    wait_done(0);
  endtask

  task automatic test_wait_states();
    int w;
    issue(3, 32'h30, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, w);
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL ws_first_grant got waited=%0d required 0", w);
    end
    issue(3, 32'h30, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, w);
    total++;
    if (w != 3) begin
      bad++;
      $display("FAIL ws_held_grant got waited=%0d required 3", w);
    end
    idle(3);
    wait_done(3);
  endtask

  task automatic test_reset_in_wait();
    int w;
    issue(2, 32'h40, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, w);
    idle(2);
    wait_done(2);
    issue(2, 32'h40, 4'b1111, 32'h12345678, 32'h0, 1'b0, 1'b0, w);
    idle(2);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    #1;
    total++;
    if (gnt[2] !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_wait_gnt got gnt=%b required 1", gnt[2]);
    end
    repeat (5) @(negedge clk);
    issue(2, 32'h40, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, w);
    idle(2);
    wait_done(2);
  endtask

  task automatic test_bounds();
    int w;
    issue(1, 32'h0, 4'b1111, 32'h5A5A0001, 32'h0, 1'b0, 1'b1, w);
`ifdef PANDA_DMEM_BOUNDS_CHECK_EN
    issue(1, 32'h1000, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, w);
`else
    issue(1, 32'h1000, 4'b0000, 32'h0, 32'h5A5A0001, 1'b0, 1'b1, w);
`endif
    idle(1);
    wait_done(1);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_reset_in_wait();
    test_bounds();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panda_data_mem_responder.md
PANDA_DATA_MEM_RESPONDER -- requirements
Module: panda_data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: memory size in 32-bit words, power of two, minimum 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states between accept and response, range 0..15.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port data_req_i  input  1  initiator request valid.
REQ-006 SHALL have port data_gnt_o  output  1  request accepted this cycle when high together with data_req_i.
REQ-007 SHALL have port data_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port data_we_i  input  4  per-byte write enables; all zero means read.
REQ-009 SHALL have port data_wdata_i  input  32  store data, byte lanes aligned to data_we_i.
REQ-010 SHALL have port data_rvalid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port data_rdata_o  output  32  full memory word for reads; zero for writes.
REQ-012 SHALL have port data_err_o  output  1  error flag, valid only while data_rvalid_o is high.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 SHALL drive data_gnt_o high in IDLE and RESP and low in WAIT, as a combinational function of state only.
REQ-015 SHALL accept a request on an edge where data_req_i and data_gnt_o are both high, registering the address, enables and write data.
REQ-016 On accept, SHALL go to WAIT with counter = WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES = 0.
REQ-017 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where it is 0.
REQ-018 SHALL perform the memory access on the edge that enters RESP: write only the byte lanes whose enable bit is 1; for reads, register the word at index addr[31:2].
REQ-019 SHALL hold data_rvalid_o high for exactly one cycle (RESP), WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 From RESP, SHALL return to IDLE unless a new request is accepted in the same cycle, in which case it follows REQ-016 (back-to-back sustained).
REQ-021 Outside RESP, SHALL hold data_rdata_o and data_err_o at 0.
REQ-022 A read in RESP directly after a write to the same word SHALL return the newly written bytes.
REQ-023 data_req_i while data_gnt_o is low SHALL NOT be accepted; the initiator holds the request until granted.

Reset
REQ-024 On rst_i high at a clock edge, SHALL set state IDLE, counter 0, data_rvalid_o 0, data_rdata_o 0 and data_err_o 0.
REQ-025 Reset during WAIT SHALL discard the pending access: no memory write and no response.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 Macro PANDA_DMEM_BOUNDS_CHECK_EN defined: if addr[31:2] >= DEPTH_WORDS, SHALL suppress the write, return rdata 0 and raise data_err_o in RESP.
REQ-028 Macro PANDA_DMEM_BOUNDS_CHECK_EN undefined: SHALL index with addr[31:2] modulo DEPTH_WORDS, hold data_err_o at 0 and add no bounds logic.

Verification
REQ-029 WAIT_CYCLES=1: write 0xDEADBEEF to 0x10 with we=1111, then read 0x10 -> each rvalid 2 cycles after its accept; read returns rdata=0xDEADBEEF.
REQ-030 Word 0x20 preset to 0x11223344; write 0x0000AA00 with we=0010 -> subsequent read returns 0x1122AA44.
REQ-031 WAIT_CYCLES=0: continuous requests held for 4 cycles -> gnt high every cycle, 4 accepts, rvalid on 4 consecutive cycles.
REQ-032 WAIT_CYCLES=3: request at cycle 0 -> gnt low during cycles 1-3, rvalid at cycle 4; a request held during cycles 1-3 is accepted at cycle 4.
REQ-033 Write 0x12345678 to 0x40 with WAIT_CYCLES=2, assert rst_i in the WAIT cycle -> no rvalid is produced and a later read of 0x40 returns the old value.
REQ-034 DEPTH_WORDS=1024, read 0x00001000 -> with the macro: err=1, rdata=0; without it: rdata equals word 0 and err=0.
